// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard for a 4-slot VLIW bundle (LSU, IXU1, IXU2, BRANCH).
// Tracks in-flight writes, stalls hazarding bundles, and counts stall cycles.
module reg_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   bundle_valid,
   input  logic                   lsu_valid,
   input  logic [4:0]             lsu_rs1,
   input  logic [4:0]             lsu_rs2,
   input  logic [4:0]             lsu_rd,
   input  logic                   lsu_wr,
   input  logic                   lsu_wb_en,
   input  logic [4:0]             lsu_wb_rd,
   input  logic                   ixu1_valid,
   input  logic [4:0]             ixu1_rs1,
   input  logic [4:0]             ixu1_rs2,
   input  logic [4:0]             ixu1_rd,
   input  logic                   ixu1_wr,
   input  logic                   ixu1_wb_en,
   input  logic [4:0]             ixu1_wb_rd,
   input  logic                   ixu2_valid,
   input  logic [4:0]             ixu2_rs1,
   input  logic [4:0]             ixu2_rs2,
   input  logic [4:0]             ixu2_rd,
   input  logic                   ixu2_wr,
   input  logic                   ixu2_wb_en,
   input  logic [4:0]             ixu2_wb_rd,
   input  logic                   branch_valid,
   input  logic [4:0]             branch_rs1,
   input  logic [4:0]             branch_rs2,
   input  logic [4:0]             branch_rd,
   input  logic                   branch_wr,
   input  logic                   branch_wb_en,
   input  logic [4:0]             branch_wb_rd,
   output logic                   issue,
   output logic                   stall,
   output logic                   hazard_raw,
   output logic                   hazard_waw,
   output logic                   bundle_err,
   output logic [NUM_REGS-1:0]    busy_vec,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int NUM_SLOTS = 4;

   logic [NUM_SLOTS-1:0]      s_valid, s_wr, s_wb;
   logic [NUM_SLOTS-1:0][4:0] s_rs1, s_rs2, s_rd, s_wb_rd;
   logic [NUM_REGS-1:0]       set_vec, clr_vec, busy_nxt;
   logic                      raw, waw, err;

   assign s_valid = {branch_valid, ixu2_valid, ixu1_valid, lsu_valid};
   assign s_wr    = {branch_wr, ixu2_wr, ixu1_wr, lsu_wr};
   assign s_wb    = {branch_wb_en, ixu2_wb_en, ixu1_wb_en, lsu_wb_en};
   assign s_rs1   = {branch_rs1, ixu2_rs1, ixu1_rs1, lsu_rs1};
   assign s_rs2   = {branch_rs2, ixu2_rs2, ixu1_rs2, lsu_rs2};
   assign s_rd    = {branch_rd, ixu2_rd, ixu1_rd, lsu_rd};
   assign s_wb_rd = {branch_wb_rd, ixu2_wb_rd, ixu1_wb_rd, lsu_wb_rd};

   // Hazards look only at registered busy bits: no same-cycle writeback bypass.
   always_comb begin
      raw = 1'b0;
      waw = 1'b0;
      err = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (s_valid[s]) begin
            if (s_rs1[s] != '0 && busy_vec[s_rs1[s]]) raw = 1'b1;
            if (s_rs2[s] != '0 && busy_vec[s_rs2[s]]) raw = 1'b1;
            if (s_wr[s] && s_rd[s] != '0 && busy_vec[s_rd[s]]) waw = 1'b1;
            for (int t = s + 1; t < NUM_SLOTS; t++) begin
               if (s_valid[t] && s_wr[s] && s_wr[t] && s_rd[s] != '0 && s_rd[s] == s_rd[t])
                  err = 1'b1;
            end
         end
      end
   end

   assign hazard_raw = bundle_valid & raw;
   assign hazard_waw = bundle_valid & waw;
   assign bundle_err = bundle_valid & err;
   assign issue      = bundle_valid & ~raw & ~waw & ~err & ~flush;
   assign stall      = bundle_valid & ~issue;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (issue && s_valid[s] && s_wr[s]) set_vec[s_rd[s]] = 1'b1;
         if (s_wb[s]) clr_vec[s_wb_rd[s]] = 1'b1;
      end
      // Set is applied after clear so a same-cycle issue wins over a writeback.
      busy_nxt = (busy_vec & ~clr_vec) | set_vec;
      if (flush) busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_vec  <= '0;
         stall_cnt <= '0;
      end else begin
         busy_vec <= busy_nxt;
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a set-of-busy-registers model is checked every
// cycle, alongside hand-computed literal expectations at key points.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst, flush, bv;
   logic        v[4], wr[4], wb[4];
   logic [4:0]  rs1[4], rs2[4], rd[4], wbr[4];
   logic        issue, stall, hraw, hwaw, berr;
   logic [31:0] busy;
   logic [15:0] scnt;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rst(rst), .flush(flush), .bundle_valid(bv),
      .lsu_valid(v[0]), .lsu_rs1(rs1[0]), .lsu_rs2(rs2[0]), .lsu_rd(rd[0]), .lsu_wr(wr[0]),
      .lsu_wb_en(wb[0]), .lsu_wb_rd(wbr[0]),
      .ixu1_valid(v[1]), .ixu1_rs1(rs1[1]), .ixu1_rs2(rs2[1]), .ixu1_rd(rd[1]), .ixu1_wr(wr[1]),
      .ixu1_wb_en(wb[1]), .ixu1_wb_rd(wbr[1]),
      .ixu2_valid(v[2]), .ixu2_rs1(rs1[2]), .ixu2_rs2(rs2[2]), .ixu2_rd(rd[2]), .ixu2_wr(wr[2]),
      .ixu2_wb_en(wb[2]), .ixu2_wb_rd(wbr[2]),
      .branch_valid(v[3]), .branch_rs1(rs1[3]), .branch_rs2(rs2[3]), .branch_rd(rd[3]),
      .branch_wr(wr[3]), .branch_wb_en(wb[3]), .branch_wb_rd(wbr[3]),
      .issue(issue), .stall(stall), .hazard_raw(hraw), .hazard_waw(hwaw),
      .bundle_err(berr), .busy_vec(busy), .stall_cnt(scnt)
   );

   // Model state: which registers have a write outstanding, and the stall count.
   logic [31:0] busy_m = '0;
   logic [15:0] cnt_m  = '0;
   bit          started = 1'b0;

   function automatic bit is_busy(logic [4:0] r);
      return (r != 5'd0) && busy_m[r];
   endfunction

   function automatic bit e_raw();
      if (!bv) return 1'b0;
      for (int s = 0; s < 4; s++)
         if (v[s] && (is_busy(rs1[s]) || is_busy(rs2[s]))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit e_waw();
      if (!bv) return 1'b0;
      for (int s = 0; s < 4; s++)
         if (v[s] && wr[s] && is_busy(rd[s])) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit e_err();
      if (!bv) return 1'b0;
      for (int r = 1; r < 32; r++) begin
         int n = 0;
         for (int s = 0; s < 4; s++)
            if (v[s] && wr[s] && rd[s] == 5'(r)) n++;
         if (n > 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit e_issue();
      return bv && !e_raw() && !e_waw() && !e_err() && !flush;
   endfunction

   function automatic bit e_stall();
      return bv && !e_issue();
   endfunction

   function automatic logic [31:0] next_busy();
      logic [31:0] nb = busy_m;
      if (flush) return '0;
      for (int r = 1; r < 32; r++) begin
         bit set = 1'b0, clr = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (e_issue() && v[s] && wr[s] && rd[s] == 5'(r)) set = 1'b1;
            if (wb[s] && wbr[s] == 5'(r)) clr = 1'b1;
         end
         if (set) nb[r] = 1'b1;
         else if (clr) nb[r] = 1'b0;
      end
      return nb;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         busy_m  <= '0;
         cnt_m   <= '0;
         started <= 1'b1;
      end else begin
         busy_m <= next_busy();
         if (e_stall() && cnt_m != 16'hFFFF) cnt_m <= cnt_m + 16'd1;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("m_issue", 32'(issue), 32'(e_issue()));
         chk("m_stall", 32'(stall), 32'(e_stall()));
         chk("m_raw",   32'(hraw),  32'(e_raw()));
         chk("m_waw",   32'(hwaw),  32'(e_waw()));
         chk("m_err",   32'(berr),  32'(e_err()));
         chk("m_busy",  busy,       busy_m);
         chk("m_cnt",   32'(scnt),  32'(cnt_m));
      end
   end

   task automatic idle();
      bv = 1'b0; flush = 1'b0;
      for (int s = 0; s < 4; s++) begin
         v[s] = 1'b0; wr[s] = 1'b0; wb[s] = 1'b0;
         rs1[s] = '0; rs2[s] = '0; rd[s] = '0; wbr[s] = '0;
      end
   endtask

   task automatic op(int s, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic w);
      v[s] = 1'b1; rs1[s] = a; rs2[s] = b; rd[s] = d; wr[s] = w;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      idle(); rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      smp(); chk("rst_busy", busy, 32'h0); chk("rst_cnt", 32'(scnt), 32'h0);
      chk("rst_issue", 32'(issue), 32'h0);

      // ixu1 writes r5: issues at once, busy next cycle
      cyc(); idle(); bv = 1'b1; op(1, 0, 0, 5, 1'b1);
      smp(); chk("t1_issue", 32'(issue), 32'h1);
      cyc(); idle();
      smp(); chk("t1_busy", busy, 32'h0000_0020);

      // RAW on r5, writeback does not bypass
      cyc(); idle(); bv = 1'b1; op(0, 5, 0, 0, 1'b0);
      smp(); chk("t2_raw", 32'(hraw), 32'h1); chk("t2_stall", 32'(stall), 32'h1);
      chk("t2_cnt0", 32'(scnt), 32'h0);
      cyc(); wb[0] = 1'b1; wbr[0] = 5'd5;
      smp(); chk("t2_wb_stall", 32'(stall), 32'h1); chk("t2_cnt1", 32'(scnt), 32'h1);
      cyc(); wb[0] = 1'b0;
      smp(); chk("t2_issue", 32'(issue), 32'h1); chk("t2_busy", busy, 32'h0);
      chk("t2_cnt2", 32'(scnt), 32'h2);

      // WAW on r7
      cyc(); idle(); bv = 1'b1; op(2, 0, 0, 7, 1'b1);
      smp(); chk("t3_first", 32'(issue), 32'h1);
      cyc(); wb[3] = 1'b1; wbr[3] = 5'd7;
      smp(); chk("t3_waw", 32'(hwaw), 32'h1); chk("t3_noissue", 32'(issue), 32'h0);
      cyc(); wb[3] = 1'b0;
      smp(); chk("t3_issue", 32'(issue), 32'h1);
      cyc(); idle(); wb[3] = 1'b1; wbr[3] = 5'd7;
      smp(); chk("t3_busy7", busy, 32'h0000_0080);
      cyc(); idle();
      smp(); chk("t3_clear", busy, 32'h0);

      // duplicate rd in one bundle; rd=0 is never a conflict
      cyc(); idle(); bv = 1'b1; op(1, 0, 0, 9, 1'b1); op(2, 0, 0, 9, 1'b1);
      smp(); chk("t4_err", 32'(berr), 32'h1); chk("t4_noissue", 32'(issue), 32'h0);
      cyc(); rd[1] = 5'd0; rd[2] = 5'd0;
      smp(); chk("t4_busy", busy, 32'h0); chk("t4_err0", 32'(berr), 32'h0);
      chk("t4_issue", 32'(issue), 32'h1);
      cyc(); idle();
      smp(); chk("t4_r0", busy, 32'h0);

      // flush drops r3/r4 and blocks issue for one cycle
      cyc(); idle(); bv = 1'b1; op(1, 0, 0, 3, 1'b1); op(2, 0, 0, 4, 1'b1);
      smp();
      cyc(); idle(); bv = 1'b1; op(0, 10, 0, 11, 1'b1); flush = 1'b1;
      smp(); chk("t5_flush_noissue", 32'(issue), 32'h0); chk("t5_busy34", busy, 32'h18);
      cyc(); flush = 1'b0;
      smp(); chk("t5_busy0", busy, 32'h0); chk("t5_issue", 32'(issue), 32'h1);
      cyc(); idle();
      smp(); chk("t5_busy11", busy, 32'h0000_0800);

      // several writebacks in one cycle, including a duplicate
      cyc(); idle(); bv = 1'b1; op(0, 0, 0, 20, 1'b1); op(3, 0, 0, 21, 1'b1);
      wb[2] = 1'b1; wbr[2] = 5'd11;
      smp();
      cyc(); idle(); wb[0] = 1'b1; wbr[0] = 5'd20; wb[1] = 1'b1; wbr[1] = 5'd21;
      wb[2] = 1'b1; wbr[2] = 5'd20;
      smp(); chk("mwb_busy", busy, 32'h0030_0000);
      cyc(); idle();
      smp(); chk("mwb_clear", busy, 32'h0);

      // set beats clear, then saturate the stall counter
      cyc(); idle(); bv = 1'b1; op(0, 0, 0, 12, 1'b1); wb[1] = 1'b1; wbr[1] = 5'd12;
      smp(); chk("t6_issue", 32'(issue), 32'h1);
      cyc(); idle(); bv = 1'b1; op(0, 12, 0, 0, 1'b0);
      smp(); chk("t6_setwins", busy, 32'h0000_1000);
      repeat (65541) cyc();
      smp(); chk("t6_sat", 32'(scnt), 32'hFFFF); chk("t6_stall", 32'(stall), 32'h1);

      // reset mid-operation; a late writeback is a no-op
      cyc(); rst = 1'b1;
      smp();
      cyc(); rst = 1'b0; idle(); wb[0] = 1'b1; wbr[0] = 5'd12;
      smp(); chk("t7_busy", busy, 32'h0); chk("t7_cnt", 32'(scnt), 32'h0);
      cyc(); idle();
      smp(); chk("t7_after", busy, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Issue-side scoreboard for the 32x32b, 4-write-port register file shared by the LSU, IXU1, IXU2 and BRANCH slots. It tracks which architectural registers have writes in flight. It stalls a VLIW bundle until all of the bundle's source and destination registers are free. It releases registers as each unit reports writeback. It also counts stall cycles for performance monitoring.

Parameters:
NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  discards all in-flight tracking; no issue this cycle
bundle_valid  input  1  a bundle is presented at issue
<s>_valid  input  1  per slot s in {lsu, ixu1, ixu2, branch}: slot holds a real op
<s>_rs1, <s>_rs2  input  5 each  per slot: source register indices
<s>_rd  input  5  per slot: destination register index
<s>_wr  input  1  per slot: op writes <s>_rd
<s>_wb_en  input  1  per slot: unit writes register file this cycle
<s>_wb_rd  input  5  per slot: register written back
issue  output  1  bundle accepted this cycle (combinational)
stall  output  1  bundle_valid & ~issue (combinational)
hazard_raw  output  1  a source register is busy (combinational)
hazard_waw  output  1  a destination register is busy (combinational)
bundle_err  output  1  two writing slots target the same nonzero rd (combinational)
busy_vec  output  NUM_REGS  registered busy bits
stall_cnt  output  STALL_CNT_W  registered saturating stall-cycle count

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: busy_vec=0 and stall_cnt=0 on the rising edge with rst=1.
  - Combinational outputs follow their equations; with bundle_valid=0 they are all 0.
  - Reset mid-operation drops all pending tracking; pending writebacks arriving afterwards are ignored because they clear non-busy bits.
- busy_vec[0] is always 0. Index 0 is never checked as a hazard and never marked busy.
- Hazards use registered busy_vec only; there is no same-cycle writeback bypass.
  - Reason: the register file updates at the clock edge, so a read in the writeback cycle returns the old value.
- RAW: any valid slot with rs1 or rs2 nonzero and busy.
- WAW: any valid slot with wr=1 and rd nonzero and busy.
- Intra-bundle reads of a register written by another slot in the same bundle are legal. They see the old value and raise no hazard.
- bundle_err: two or more valid slots with wr=1 share the same nonzero rd.
  - The bundle never issues while err=1.
  - This is a compiler error; the stall persists until upstream changes the bundle.
- issue = bundle_valid & ~hazard_raw & ~hazard_waw & ~bundle_err & ~flush. Issue is zero-latency, in the same cycle.
- Next-state of each busy bit r (r != 0):
  - flush=1: cleared, overriding everything.
  - Set if issue and any valid writing slot has rd==r.
  - Otherwise cleared if any <s>_wb_en with <s>_wb_rd==r.
  - Otherwise held.
- Set beats clear for the same r in the same cycle. Writeback to a non-busy register is a no-op.
- Multiple writebacks in one cycle clear all named bits. Duplicate wb_rd values are harmless.
- A newly set bit is visible to hazard checks in the next cycle.
- stall_cnt increments by 1 each cycle stall=1. It saturates at all-ones and clears only on rst. flush does not clear it.
- Writing unit latencies are arbitrary (1..N cycles). The scoreboard relies solely on <s>_wb_en.

Test Plan:
- Reset, then present ixu1 writing r5 (wr=1, rd=5) -> issue=1 in the same cycle; busy_vec=0x0000_0020 in the next cycle.
- With r5 busy, present lsu reading rs1=5 -> hazard_raw=1, stall=1, stall_cnt increments each cycle. Pulse lsu_wb_en with wb_rd=5 -> stall persists that cycle; issue=1 in the following cycle.
- With r7 busy, present ixu2 rd=7 wr=1 -> hazard_waw=1, no issue. branch_wb_en with wb_rd=7 clears it; issue next cycle.
- ixu1 and ixu2 both wr=1 with rd=9 -> bundle_err=1, issue=0, busy_vec unchanged. Both with rd=0 -> bundle_err=0, issue=1, busy_vec[0] stays 0.
- Busy r3 and r4, assert flush with a hazard-free bundle -> issue=0 that cycle; busy_vec=0 next cycle; the same bundle then issues.
- Same cycle: issue of lsu rd=12 and spurious ixu1_wb_en with wb_rd=12 -> busy_vec[12]=1 (set wins). Hold stall for 2^16+5 cycles -> stall_cnt=0xFFFF.
